// File: rtl/wb_regfile_pkg.sv
// Shared widths and types for the write-back register file slice.
package wb_regfile_pkg;

   localparam int RegWidth     = 32;
   localparam int RegAddrWidth = 5;
   localparam int CSRAddrWidth = 14;
   localparam int RegNum       = 1 << RegAddrWidth;

   typedef struct packed {
      logic                    en;
      logic [CSRAddrWidth-1:0] addr;
      logic [RegWidth-1:0]     data;
   } csr_req_t;

endpackage

// File: rtl/wb_regfile_bank.sv
// 32-entry GPR bank: two combinational read ports, one write port, r0 hardwired to zero.
module regfile_bank
   import wb_regfile_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we_i,
   input  logic [RegAddrWidth-1:0] waddr_i,
   input  logic [RegWidth-1:0]     wdata_i,
   input  logic [RegAddrWidth-1:0] raddr1_i,
   input  logic [RegAddrWidth-1:0] raddr2_i,
   output logic [RegWidth-1:0]     rdata1_o,
   output logic [RegWidth-1:0]     rdata2_o
);

   logic [RegNum-1:0][RegWidth-1:0] regs_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q <= '0;
      end else if (we_i && (waddr_i != '0)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // r0 is forced at the read side so the storage for entry 0 is never relied on
   assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
   assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: GPR bank, LLbit, registered CSR write port.
// Optional same-cycle write-to-read bypass is enabled with `define WB_BYPASS_EN.
module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    wb_reg_write_en,
   input  logic [RegAddrWidth-1:0] wb_reg_write_addr,
   input  logic [RegWidth-1:0]     wb_reg_write_data,

   input  logic                    wb_LLbit_write_en,
   input  logic                    wb_LLbit_write_data,

   input  logic                    wb_csr_write_en,
   input  logic [CSRAddrWidth-1:0] wb_csr_write_addr,
   input  logic [RegWidth-1:0]     wb_csr_write_data,

   input  logic                    excp_flush,

   input  logic                    reg1_read_en,
   input  logic [RegAddrWidth-1:0] reg1_read_addr,
   output logic [RegWidth-1:0]     reg1_read_data,
   input  logic                    reg2_read_en,
   input  logic [RegAddrWidth-1:0] reg2_read_addr,
   output logic [RegWidth-1:0]     reg2_read_data,

   output logic                    LLbit,

   output logic                    csr_write_en,
   output logic [CSRAddrWidth-1:0] csr_write_addr,
   output logic [RegWidth-1:0]     csr_write_data
);

   logic [RegWidth-1:0] bank_rdata1, bank_rdata2;
   logic                llbit_q, llbit_d;
   csr_req_t            csr_q, csr_d;

   regfile_bank u_bank (
      .clk      (clk),
      .rst      (rst),
      .we_i     (wb_reg_write_en),
      .waddr_i  (wb_reg_write_addr),
      .wdata_i  (wb_reg_write_data),
      .raddr1_i (reg1_read_addr),
      .raddr2_i (reg2_read_addr),
      .rdata1_o (bank_rdata1),
      .rdata2_o (bank_rdata2)
   );

`ifdef WB_BYPASS_EN
   // Bypass only when the write will actually commit; during reset reads show the array
   logic byp1, byp2;
   assign byp1 = rst && wb_reg_write_en && (wb_reg_write_addr != '0)
                 && (wb_reg_write_addr == reg1_read_addr);
   assign byp2 = rst && wb_reg_write_en && (wb_reg_write_addr != '0)
                 && (wb_reg_write_addr == reg2_read_addr);
`else
   logic byp1, byp2;
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   always_comb begin
      reg1_read_data = '0;
      reg2_read_data = '0;
      if (reg1_read_en) reg1_read_data = byp1 ? wb_reg_write_data : bank_rdata1;
      if (reg2_read_en) reg2_read_data = byp2 ? wb_reg_write_data : bank_rdata2;
   end

   always_comb begin
      llbit_d = llbit_q;
      if (excp_flush)             llbit_d = 1'b0;
      else if (wb_LLbit_write_en) llbit_d = wb_LLbit_write_data;
   end

   // Idle cycles carry zero address/data so the CSR unit never sees stale values
   always_comb begin
      csr_d = '0;
      if (wb_csr_write_en) begin
         csr_d.en   = 1'b1;
         csr_d.addr = wb_csr_write_addr;
         csr_d.data = wb_csr_write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         llbit_q <= 1'b0;
         csr_q   <= '0;
      end else begin
         llbit_q <= llbit_d;
         csr_q   <= csr_d;
      end
   end

   assign LLbit          = llbit_q;
   assign csr_write_en   = csr_q.en;
   assign csr_write_addr = csr_q.addr;
   assign csr_write_data = csr_q.data;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; expectations follow WB_BYPASS_EN when defined.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_reg_write_en;
   logic [4:0]  wb_reg_write_addr;
   logic [31:0] wb_reg_write_data;
   logic        wb_LLbit_write_en, wb_LLbit_write_data;
   logic        wb_csr_write_en;
   logic [13:0] wb_csr_write_addr;
   logic [31:0] wb_csr_write_data;
   logic        excp_flush;
   logic        reg1_read_en, reg2_read_en;
   logic [4:0]  reg1_read_addr, reg2_read_addr;
   logic [31:0] reg1_read_data, reg2_read_data;
   logic        LLbit;
   logic        csr_write_en;
   logic [13:0] csr_write_addr;
   logic [31:0] csr_write_data;

   int nvec = 0;
   int nerr = 0;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk                 (clk),
      .rst                 (rst),
      .wb_reg_write_en     (wb_reg_write_en),
      .wb_reg_write_addr   (wb_reg_write_addr),
      .wb_reg_write_data   (wb_reg_write_data),
      .wb_LLbit_write_en   (wb_LLbit_write_en),
      .wb_LLbit_write_data (wb_LLbit_write_data),
      .wb_csr_write_en     (wb_csr_write_en),
      .wb_csr_write_addr   (wb_csr_write_addr),
      .wb_csr_write_data   (wb_csr_write_data),
      .excp_flush          (excp_flush),
      .reg1_read_en        (reg1_read_en),
      .reg1_read_addr      (reg1_read_addr),
      .reg1_read_data      (reg1_read_data),
      .reg2_read_en        (reg2_read_en),
      .reg2_read_addr      (reg2_read_addr),
      .reg2_read_data      (reg2_read_data),
      .LLbit               (LLbit),
      .csr_write_en        (csr_write_en),
      .csr_write_addr      (csr_write_addr),
      .csr_write_data      (csr_write_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_reg_write_en = 0; wb_reg_write_addr = 0; wb_reg_write_data = 0;
      wb_LLbit_write_en = 0; wb_LLbit_write_data = 0;
      wb_csr_write_en = 0; wb_csr_write_addr = 0; wb_csr_write_data = 0;
      excp_flush = 0;
   endtask

   task automatic gpr_wr(input logic [4:0] a, input logic [31:0] d);
      wb_reg_write_en = 1; wb_reg_write_addr = a; wb_reg_write_data = d;
   endtask

   initial begin
      rst = 0;
      idle();
      reg1_read_en = 1; reg1_read_addr = 0;
      reg2_read_en = 1; reg2_read_addr = 0;
      tick(); tick();
      chk("init_llbit", {31'd0, LLbit}, 32'd0);
      chk("init_csr_en", {31'd0, csr_write_en}, 32'd0);

      // populate state, then reset with a write pending
      rst = 1;
      gpr_wr(5'd3, 32'h0000_1111); tick();
      gpr_wr(5'd12, 32'hCAFE_F00D); wb_LLbit_write_en = 1; wb_LLbit_write_data = 1;
      wb_csr_write_en = 1; wb_csr_write_addr = 14'h0AB; wb_csr_write_data = 32'h1;
      tick();
      idle(); gpr_wr(5'd31, 32'h7777_7777); tick();
      reg1_read_addr = 5'd12; #1;
      chk("pre_reset_r12", reg1_read_data, 32'hCAFE_F00D);
      chk("pre_reset_llbit", {31'd0, LLbit}, 32'd1);

      rst = 0; gpr_wr(5'd3, 32'h0000_00FF);
      wb_LLbit_write_en = 1; wb_LLbit_write_data = 1;
      wb_csr_write_en = 1; wb_csr_write_addr = 14'h006; wb_csr_write_data = 32'h4;
      tick(); tick();
      for (int a = 0; a < 32; a++) begin
         reg1_read_addr = 5'(a); reg2_read_addr = 5'(31 - a); #1;
         chk($sformatf("rst_r1_%0d", a), reg1_read_data, 32'd0);
         chk($sformatf("rst_r2_%0d", 31 - a), reg2_read_data, 32'd0);
      end
      chk("rst_llbit", {31'd0, LLbit}, 32'd0);
      chk("rst_csr_en", {31'd0, csr_write_en}, 32'd0);
      chk("rst_csr_addr", {18'd0, csr_write_addr}, 32'd0);
      chk("rst_csr_data", csr_write_data, 32'd0);

      // first edge with rst=1 accepts the write
      idle(); rst = 1; gpr_wr(5'd4, 32'h0000_0044); tick();
      idle();
      reg1_read_addr = 5'd3; reg2_read_addr = 5'd4; #1;
      chk("r3_after_rst", reg1_read_data, 32'd0);
      chk("r4_first_write", reg2_read_data, 32'h0000_0044);

      gpr_wr(5'd5, 32'hDEAD_BEEF); tick(); idle();
      reg1_read_addr = 5'd5; reg2_read_addr = 5'd5; reg2_read_en = 0; #1;
      chk("r5_read", reg1_read_data, 32'hDEAD_BEEF);
      chk("rd_en_off", reg2_read_data, 32'd0);
      reg2_read_en = 1;

      gpr_wr(5'd0, 32'h0000_1234); tick(); idle();
      reg1_read_addr = 5'd0; #1;
      chk("r0_read", reg1_read_data, 32'd0);
      gpr_wr(5'd0, 32'h0000_1234); #1;
      chk("r0_byp", reg1_read_data, 32'd0);
      idle();

      gpr_wr(5'd7, 32'h0000_0001); tick();
      gpr_wr(5'd7, 32'hA5A5_A5A5);
      reg1_read_addr = 5'd7; reg2_read_addr = 5'd7; #1;
      chk("r7_same_cyc_p1", reg1_read_data, BYP ? 32'hA5A5_A5A5 : 32'h0000_0001);
      chk("r7_same_cyc_p2", reg2_read_data, BYP ? 32'hA5A5_A5A5 : 32'h0000_0001);
      reg2_read_addr = 5'd5; #1;
      chk("r5_no_byp", reg2_read_data, 32'hDEAD_BEEF);
      tick(); idle(); #1;
      chk("r7_after", reg1_read_data, 32'hA5A5_A5A5);

      wb_LLbit_write_en = 1; wb_LLbit_write_data = 1; tick();
      chk("llbit_set", {31'd0, LLbit}, 32'd1);
      excp_flush = 1; tick();
      chk("llbit_flush", {31'd0, LLbit}, 32'd0);
      excp_flush = 0; tick();
      wb_LLbit_write_data = 0; tick();
      chk("llbit_wr0", {31'd0, LLbit}, 32'd0);
      idle();

      wb_csr_write_en = 1; wb_csr_write_addr = 14'h006; wb_csr_write_data = 32'h4; #1;
      chk("csr_n_en", {31'd0, csr_write_en}, 32'd0);
      tick(); idle();
      chk("csr_n1_en", {31'd0, csr_write_en}, 32'd1);
      chk("csr_n1_addr", {18'd0, csr_write_addr}, 32'h006);
      chk("csr_n1_data", csr_write_data, 32'h4);
      tick();
      chk("csr_n2_en", {31'd0, csr_write_en}, 32'd0);
      chk("csr_n2_addr", {18'd0, csr_write_addr}, 32'd0);
      chk("csr_n2_data", csr_write_data, 32'd0);

      // all three commits in one cycle
      gpr_wr(5'd31, 32'h0BAD_CAFE); wb_LLbit_write_en = 1; wb_LLbit_write_data = 1;
      wb_csr_write_en = 1; wb_csr_write_addr = 14'h3FFF; wb_csr_write_data = 32'hFFFF_FFFF;
      tick();
      wb_csr_write_addr = 14'h0001; wb_csr_write_data = 32'h1234_5678;
      wb_reg_write_en = 0; wb_LLbit_write_en = 0;
      reg1_read_addr = 5'd31; #1;
      chk("mix_r31", reg1_read_data, 32'h0BAD_CAFE);
      chk("mix_llbit", {31'd0, LLbit}, 32'd1);
      chk("mix_csr_en", {31'd0, csr_write_en}, 32'd1);
      chk("mix_csr_addr", {18'd0, csr_write_addr}, 32'h3FFF);
      chk("mix_csr_data", csr_write_data, 32'hFFFF_FFFF);
      tick(); idle();
      chk("b2b_csr_en", {31'd0, csr_write_en}, 32'd1);
      chk("b2b_csr_addr", {18'd0, csr_write_addr}, 32'h0001);
      chk("b2b_csr_data", csr_write_data, 32'h1234_5678);
      tick();
      chk("b2b_csr_done", {31'd0, csr_write_en}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
